// File: rtl/wb_arb_pkg.sv
// Shared definitions for the Wishbone SDRAM-port arbiter: FSM states and cti codes.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } arb_state_e;

  localparam logic [2:0] CLASSIC = 3'b000;
  localparam logic [2:0] INCR    = 3'b010;
  localparam logic [2:0] EOB     = 3'b111;

endpackage

// File: rtl/wb_sdram_arbiter_rr_pick.sv
// Round-robin one-hot selector: lowest requesting index >= ptr wins, wrapping to index 0.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is registered.
module wb_rr_pick #(
  parameter int NUM_MASTERS = 2,
  parameter int PW          = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [PW-1:0]          ptr,
  output logic [NUM_MASTERS-1:0] gnt
);

  // First pass searches ptr..top, second pass wraps to 0..ptr-1 if nothing was found.
  always_comb begin
    logic found;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!found && req[k] && (k >= int'(ptr))) begin
        gnt[k] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!found && req[k]) begin
        gnt[k] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_sdram_arbiter.sv
// Round-robin Wishbone arbiter sharing the SDRAM controller slave port; grant held per bus cycle.
// Latency: one registered cycle from cyc to grant, then combinational pass-through per beat.
// Backpressure: losers stall with no ack; a beat stalled TIMEOUT_CYCLES is killed with a one-cycle err.
module wb_sdram_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
  input  logic [NUM_MASTERS-1:0]      m_we_i,
  input  logic [NUM_MASTERS-1:0]      m_cyc_i,
  input  logic [NUM_MASTERS-1:0]      m_stb_i,
  input  logic [NUM_MASTERS*3-1:0]    m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]    m_bte_i,
  output logic [DW-1:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]      m_ack_o,
  output logic [NUM_MASTERS-1:0]      m_err_o,
  output logic [AW-1:0]               s_adr_o,
  output logic [DW-1:0]               s_dat_o,
  output logic [DW/8-1:0]             s_sel_o,
  output logic                        s_we_o,
  output logic                        s_cyc_o,
  output logic                        s_stb_o,
  output logic [2:0]                  s_cti_o,
  output logic [1:0]                  s_bte_o,
  input  logic [DW-1:0]               s_dat_i,
  input  logic                        s_ack_i,
  input  logic                        s_err_i,
  output logic [NUM_MASTERS-1:0]      grant_o
);

  localparam int SW    = DW / 8;
  localparam int PW    = $clog2(NUM_MASTERS);
  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
  // A zero timeout still needs a 1-bit counter to keep the declarations legal; it never counts.
  localparam int CW    = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] WD_LIMIT = CW'(TIMEOUT_CYCLES);

  arb_state_e             state;
  logic [NUM_MASTERS-1:0] grant;
  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [PW-1:0]          gidx;
  logic [PW-1:0]          pick_idx;
  logic [PW-1:0]          ptr;
  logic [PW-1:0]          next_ptr;
  logic [CW-1:0]          wd_cnt;
  logic                   err_pulse;
  logic                   g_cyc;
  logic                   g_stb;
  logic                   busy;
  logic                   stall;

  wb_rr_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .PW          (PW)
  ) u_pick (
    .req (m_cyc_i),
    .ptr (ptr),
    .gnt (pick_gnt)
  );

  // Encode the one-hot pick so the owner index can be stored for pointer rotation.
  always_comb begin
    pick_idx = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (pick_gnt[k]) pick_idx = PW'(k);
    end
  end

  // Slave-side mux: an AND-OR over the one-hot grant, so an empty grant yields all zeros.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cti_o = '0;
    s_bte_o = '0;
    g_cyc   = 1'b0;
    g_stb   = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (grant[k]) begin
        s_adr_o = m_adr_i[k*AW +: AW];
        s_dat_o = m_dat_i[k*DW +: DW];
        s_sel_o = m_sel_i[k*SW +: SW];
        s_we_o  = m_we_i[k];
        s_cti_o = m_cti_i[k*3 +: 3];
        s_bte_o = m_bte_i[k*2 +: 2];
        g_cyc   = m_cyc_i[k];
        g_stb   = m_stb_i[k];
      end
    end
  end

  // cyc/stb only reach the slave in BUSY; ERR keeps the grant but kills the bus cycle.
  assign busy     = (state == BUSY);
  assign s_cyc_o  = busy & g_cyc;
  assign s_stb_o  = busy & g_cyc & g_stb;
  assign stall    = s_stb_o & ~s_ack_i & ~s_err_i;
  assign m_dat_o  = s_dat_i;
  assign m_ack_o  = busy ? (grant & {NUM_MASTERS{s_ack_i}}) : '0;
  assign m_err_o  = busy ? (grant & {NUM_MASTERS{s_err_i}})
                         : ((state == ERR) ? (grant & {NUM_MASTERS{err_pulse}}) : '0);
  assign grant_o  = grant;
  assign next_ptr = (gidx == PW'(NUM_MASTERS - 1)) ? '0 : gidx + 1'b1;

  // Arbitration FSM with grant register, rotating pointer, watchdog and err pulse.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      grant     <= '0;
      gidx      <= '0;
      ptr       <= '0;
      wd_cnt    <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (|m_cyc_i) begin
            grant <= pick_gnt;
            gidx  <= pick_idx;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (!g_cyc) begin
            grant  <= '0;
            ptr    <= next_ptr;
            wd_cnt <= '0;
            state  <= IDLE;
          end else if (WD_EN && stall) begin
            // Counting happens only on stalled beats, so an ack in the would-be expiry cycle wins.
            if ((wd_cnt + 1'b1) == WD_LIMIT) begin
              wd_cnt    <= WD_LIMIT;
              err_pulse <= 1'b1;
              state     <= ERR;
            end else begin
              wd_cnt <= wd_cnt + 1'b1;
            end
          end else begin
            wd_cnt <= '0;
          end
        end
        ERR: begin
          if (!g_cyc) begin
            grant  <= '0;
            ptr    <= next_ptr;
            wd_cnt <= '0;
            state  <= IDLE;
          end
        end
        default: begin
          grant  <= '0;
          wd_cnt <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
